huffman_enc_arb: RTL and testbench

Round-robin scheduler that shares one `Huffman_enc` bit packer between N independent symbol sources, e.g. per-channel CNN weight compressors. It grants the packer to one requester for a burst of up to BURST symbols and forwards that requester's variable-width codes. At every burst end it inserts a zero pad code so that each requester's segment ends on a W-bit boundary of the packed stream. It sits directly in front of `Huffman_enc` and drives that block's `d_in`/`w_in`/`en_in`.

---
 rtl/huffman_enc_arb.sv | 96 +++++++++
 tb/tb_huffman_enc_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_enc_arb.sv
// huffman_enc_arb: round-robin burst scheduler sharing one Huffman_enc packer among N sources,
// zero-padding every burst so each requester's segment ends on a W-bit boundary.
module huffman_enc_arb #(
  parameter int W     = 8,
  parameter int C     = 4,
  parameter int N     = 4,
  parameter int BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  output logic [N-1:0]          req_ready,
  input  logic [N*W-1:0]        req_d,
  input  logic [N*C-1:0]        req_w,
  input  logic [N-1:0]          req_last,
  output logic [W-1:0]          enc_d_in,
  output logic [C-1:0]          enc_w_in,
  output logic                  enc_en_in,
  output logic [$clog2(N)-1:0]  grant_id,
  output logic                  grant_vld,
  output logic                  busy
);
  localparam int GW = $clog2(N);
  localparam int BW = $clog2(W);
  localparam int SW = $clog2(BURST + 1);
  typedef enum logic [1:0] {IDLE, ARB, XFER, PAD} state_t;
  state_t state, state_n;
  logic [GW-1:0] rr_ptr, sel, idx;
  logic found, acc, burst_end;
  logic [BW-1:0] bit_cnt, bit_nx;
  logic [SW-1:0] sym_cnt;
  logic [C-1:0] w_in, w_eff;
  logic [C:0] sum;
  always_comb begin
    sel = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = GW'((int'(rr_ptr) + k) % N);
      if (!found && req_valid[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  assign acc       = state == XFER && req_valid[grant_id];
  assign req_ready = acc ? (N'(1) << grant_id) : '0;
  assign w_in      = req_w[int'(grant_id)*C +: C];
  assign w_eff     = w_in > C'(W) ? C'(W) : w_in;
  assign sum       = {1'b0, w_eff} + (C+1)'(bit_cnt);
  assign bit_nx    = sum >= (C+1)'(W) ? BW'(sum - (C+1)'(W)) : BW'(sum);
  assign burst_end = sym_cnt == SW'(BURST - 1);
  assign busy      = state != IDLE;
  // A burst ends on BURST symbols, on last, or as soon as the owner has nothing to send.
  always_comb begin
    state_n = state == IDLE ? (|req_valid ? ARB : IDLE)
            : state == ARB  ? (found ? XFER : IDLE)
            : state == XFER ? ((!acc || burst_end || req_last[grant_id]) ? PAD : XFER)
            : ARB;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= GW'(N - 1);
      bit_cnt   <= '0;
      sym_cnt   <= '0;
      enc_d_in  <= '0;
      enc_w_in  <= '0;
      enc_en_in <= 1'b0;
      grant_id  <= '0;
      grant_vld <= 1'b0;
    end else begin
      state     <= state_n;
      grant_vld <= state_n == XFER || state_n == PAD;
      enc_en_in <= 1'b0;
      if (state == ARB && found) begin
        grant_id <= sel;
        rr_ptr   <= sel;
        sym_cnt  <= '0;
      end
      if (acc) begin
        enc_d_in  <= req_d[int'(grant_id)*W +: W];
        enc_w_in  <= w_eff;
        enc_en_in <= w_eff != '0;
        sym_cnt   <= sym_cnt + 1'b1;
        bit_cnt   <= bit_nx;
      end
      if (state == PAD && bit_cnt != '0) begin
        enc_d_in  <= '0;
        enc_w_in  <= C'(W) - C'(bit_cnt);
        enc_en_in <= 1'b1;
        bit_cnt   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_huffman_enc_arb.sv
// tb_huffman_enc_arb: randomized and directed checks of huffman_enc_arb against a
// per-requester queue model of round-robin bursts with boundary padding.
module tb_huffman_enc_arb;
  localparam int W = 8, C = 4, N = 4, BURST = 8;
  typedef struct packed {logic [W-1:0] d; logic [C-1:0] w; logic last;} sym_t;
  logic clk = 0, rst = 0;
  logic [N-1:0] req_valid = '0, req_ready, req_last = '0;
  logic [N*W-1:0] req_d = '0;
  logic [N*C-1:0] req_w = '0;
  logic [W-1:0] enc_d_in;
  logic [C-1:0] enc_w_in;
  logic enc_en_in, grant_vld, busy;
  logic [$clog2(N)-1:0] grant_id;
  sym_t mem [N][64];
  int len [N], hd [N];
  logic [W+C-1:0] got_s[$], exp_s[$];
  int got_c[$], got_g[$], exp_g[$];
  logic [7:0] bytes_q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic gv_q = 0;
  bit to;

  huffman_enc_arb #(.W(W), .C(C), .N(N), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_d(req_d),
    .req_w(req_w), .req_last(req_last), .enc_d_in(enc_d_in), .enc_w_in(enc_w_in),
    .enc_en_in(enc_en_in), .grant_id(grant_id), .grant_vld(grant_vld), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst) begin
      if (enc_en_in) begin
        got_s.push_back({enc_d_in, enc_w_in});
        got_c.push_back(cyc);
      end
      if (grant_vld && !gv_q) got_g.push_back(int'(grant_id));
      gv_q <= grant_vld;
    end else gv_q <= 1'b0;
  end

  function automatic void clear_all();
    got_s.delete(); got_c.delete(); got_g.delete(); exp_s.delete(); exp_g.delete();
    for (int i = 0; i < N; i++) begin len[i] = 0; hd[i] = 0; end
  endfunction

  task automatic do_reset();
    rst = 0; req_valid = '0; req_last = '0;
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic add(input int r, input logic [W-1:0] dd, input logic [C-1:0] ww, input logic ll);
    mem[r][len[r]] = {dd, ww, ll};
    len[r]++;
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < N; i++) if (hd[i] < len[i]) p = 1;
    return p;
  endfunction

  // Abstract reference: whole bursts taken from per-requester queues, padded to W bits.
  function automatic void model();
    int h [N];
    int p = N - 1, g, bits, cnt, we;
    sym_t s;
    for (int i = 0; i < N; i++) h[i] = hd[i];
    while (1) begin
      g = -1;
      for (int k = 1; k <= N; k++) if (g < 0 && h[(p + k) % N] < len[(p + k) % N]) g = (p + k) % N;
      if (g < 0) break;
      p = g; exp_g.push_back(g); bits = 0; cnt = 0;
      while (h[g] < len[g]) begin
        s = mem[g][h[g]]; h[g]++;
        we = int'(s.w) > W ? W : int'(s.w);
        if (we > 0) exp_s.push_back({s.d, C'(we)});
        bits = (bits + we) % W; cnt++;
        if (cnt == BURST || s.last) break;
      end
      if (bits != 0) exp_s.push_back({{W{1'b0}}, C'(W - bits)});
    end
  endfunction

  function automatic void pack_got();
    logic [7:0] acc = '0;
    logic [W-1:0] d;
    int nb = 0;
    bytes_q.delete();
    foreach (got_s[j]) begin
      d = got_s[j][W+C-1:C];
      for (int b = 0; b < int'(got_s[j][C-1:0]); b++) begin
        acc = {acc[6:0], d[W-1-b]}; nb++;
        if (nb == 8) begin bytes_q.push_back(acc); nb = 0; end
      end
    end
  endfunction

  task automatic run_traffic(input int budget, output bit tmo);
    logic [N-1:0] rdy;
    int n = 0;
    while (n < budget && (pending() || busy)) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = hd[i] < len[i];
        req_d[i*W +: W] = mem[i][hd[i] % 64].d;
        req_w[i*C +: C] = mem[i][hd[i] % 64].w;
        req_last[i] = req_valid[i] && mem[i][hd[i] % 64].last;
      end
      #1 rdy = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) if (rdy[i]) hd[i]++;
      n++;
    end
    tmo = n >= budget;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if ({enc_d_in, enc_w_in, enc_en_in, grant_id, grant_vld, busy, req_ready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", {enc_d_in, enc_w_in, enc_en_in, grant_id, grant_vld, busy, req_ready});
    end
    do_reset();
  endtask

  task automatic test_aligned();
    do_reset();
    add(0, 8'h00, 2, 0); add(0, 8'h40, 2, 0); add(0, 8'h00, 2, 0); add(0, 8'h40, 2, 1);
    model(); run_traffic(200, to); pack_got();
    n_chk++; if (to) begin n_fail++; $display("FAIL aligned_timeout: budget expired"); end
    n_chk++; if (got_s.size() != 4) begin n_fail++; $display("FAIL aligned_strobes: got %0d required 4", got_s.size()); end
    for (int j = 0; j < 4 && j < got_s.size(); j++) begin
      n_chk++; if (got_s[j] !== exp_s[j]) begin n_fail++; $display("FAIL aligned_code[%0d]: got %h required %h", j, got_s[j], exp_s[j]); end
    end
    n_chk++; if (bytes_q.size() != 1 || bytes_q[0] !== 8'h11) begin n_fail++; $display("FAIL aligned_byte: got %p required 11", bytes_q); end
  endtask

  task automatic test_pad();
    do_reset();
    add(1, 8'h80, 3, 0); add(1, 8'hA0, 3, 0); add(1, 8'h80, 3, 1);
    model(); run_traffic(200, to); pack_got();
    n_chk++; if (to) begin n_fail++; $display("FAIL pad_timeout: budget expired"); end
    n_chk++; if (got_s.size() != 4 || got_s[3] !== {8'h00, 4'd7}) begin n_fail++; $display("FAIL pad_strobe: got %p required 4 strobes ending 007", got_s); end
    n_chk++; if (bytes_q.size() != 2 || bytes_q[0] !== 8'h96 || bytes_q[1] !== 8'h00) begin n_fail++; $display("FAIL pad_bytes: got %p required 96 00", bytes_q); end
  endtask

  task automatic test_round_robin();
    int req_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int r = 0; r < N; r++) for (int k = 0; k < 10; k++) add(r, W'($urandom), 8, 0);
    model(); run_traffic(500, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL rr_timeout: budget expired"); end
    n_chk++; if (got_s.size() != exp_s.size()) begin n_fail++; $display("FAIL rr_count: got %0d required %0d", got_s.size(), exp_s.size()); end
    for (int j = 0; j < exp_s.size() && j < got_s.size(); j++) begin
      n_chk++; if (got_s[j] !== exp_s[j]) begin n_fail++; $display("FAIL rr_code[%0d]: got %h required %h", j, got_s[j], exp_s[j]); end
    end
    for (int j = 0; j < 5; j++) begin
      n_chk++; if (j >= got_g.size() || got_g[j] != req_g[j]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %p required %0d", j, got_g, req_g[j]); end
    end
    for (int j = 1; j <= 32 && j < got_c.size(); j++) begin
      n_chk++; if (got_c[j] - got_c[j-1] != (j % 8 == 0 ? 3 : 1)) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d required %0d", j, got_c[j] - got_c[j-1], j % 8 == 0 ? 3 : 1); end
    end
  endtask

  task automatic test_valid_drop();
    do_reset();
    for (int k = 0; k < 3; k++) add(2, W'($urandom), 5, 0);
    add(3, 8'hC3, 8, 0); add(3, 8'h3C, 8, 1);
    model(); run_traffic(200, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL drop_timeout: budget expired"); end
    n_chk++; if (got_s.size() != 6 || got_s[3] !== {8'h00, 4'd1}) begin n_fail++; $display("FAIL drop_pad: got %p required pad 001 at index 3", got_s); end
    n_chk++; if (got_g.size() != 2 || got_g[0] != 2 || got_g[1] != 3) begin n_fail++; $display("FAIL drop_grants: got %p required 2 3", got_g); end
    for (int j = 0; j < exp_s.size() && j < got_s.size(); j++) begin
      n_chk++; if (got_s[j] !== exp_s[j]) begin n_fail++; $display("FAIL drop_code[%0d]: got %h required %h", j, got_s[j], exp_s[j]); end
    end
  endtask

  task automatic test_width_edges();
    do_reset();
    add(0, 8'hFF, 0, 0);
    for (int k = 0; k < 7; k++) add(0, W'(k * 17), 8, 0);
    add(0, 8'hAB, 12, 1);
    model(); run_traffic(200, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL width_timeout: budget expired"); end
    n_chk++; if (got_s.size() != 8 || got_s[7] !== {8'hAB, 4'd8}) begin n_fail++; $display("FAIL width_clamp: got %p required 8 strobes ending AB8", got_s); end
    n_chk++; if (got_g.size() != 2) begin n_fail++; $display("FAIL width_grants: got %0d required 2", got_g.size()); end
    for (int j = 0; j < exp_s.size() && j < got_s.size(); j++) begin
      n_chk++; if (got_s[j] !== exp_s[j]) begin n_fail++; $display("FAIL width_code[%0d]: got %h required %h", j, got_s[j], exp_s[j]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int r = 0; r < N; r++) begin
        int ns = $urandom_range(0, 14);
        for (int k = 0; k < ns; k++) add(r, W'($urandom), C'($urandom_range(0, 12)), $urandom_range(0, 3) == 0);
      end
      model(); run_traffic(2000, to);
      n_chk++; if (to) begin n_fail++; $display("FAIL rand_timeout[%0d]: budget expired", it); end
      n_chk++; if (got_s.size() != exp_s.size()) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d required %0d", it, got_s.size(), exp_s.size()); end
      for (int j = 0; j < exp_s.size() && j < got_s.size(); j++) begin
        n_chk++; if (got_s[j] !== exp_s[j]) begin n_fail++; $display("FAIL rand_code[%0d][%0d]: got %h required %h", it, j, got_s[j], exp_s[j]); end
      end
      n_chk++; if (got_g != exp_g) begin n_fail++; $display("FAIL rand_grants[%0d]: got %p required %p", it, got_g, exp_g); end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    do_reset();
    @(negedge clk);
    req_valid = 4'b0010; req_d[W +: W] = 8'h5A; req_w[C +: C] = 4'd8;
    while (got_s.size() < 2 && n < 20) begin @(posedge clk); #2; n++; end
    n_chk++; if (n >= 20) begin n_fail++; $display("FAIL areset_wait: budget expired"); end
    rst = 0; #1;
    n_chk++;
    if ({enc_d_in, enc_w_in, enc_en_in, grant_id, grant_vld, busy, req_ready} !== '0) begin
      n_fail++; $display("FAIL areset_outputs: got %h required 0", {enc_d_in, enc_w_in, enc_en_in, grant_id, grant_vld, busy, req_ready});
    end
    req_valid = '0;
    clear_all();
    @(negedge clk);
    rst = 1;
    add(1, 8'h11, 8, 1); add(0, 8'h22, 4, 1);
    model(); run_traffic(200, to);
    n_chk++; if (to) begin n_fail++; $display("FAIL areset_timeout: budget expired"); end
    n_chk++; if (got_g.size() == 0 || got_g[0] != 0) begin n_fail++; $display("FAIL areset_first_grant: got %p required 0 first", got_g); end
    n_chk++; if (got_s != exp_s) begin n_fail++; $display("FAIL areset_codes: got %p required %p", got_s, exp_s); end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_pad();
    test_round_robin();
    test_valid_drop();
    test_width_edges();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
